// File: rtl/ripple_count_checker.sv
// Synchronizes and de-glitches the outputs of a ripple up/down counter, then
// classifies every accepted value as a legal step, a wrap, or a step error.
module ripple_count_checker #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             m,
  output logic [WIDTH-1:0] count_out,
  output logic             count_valid,
  output logic             wrap,
  output logic             step_err,
  output logic [7:0]       err_count
);

  typedef enum logic {INIT, TRACK} state_t;

  localparam logic [3:0]       SETTLE_L = 4'(SETTLE);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  state_t           state, state_next;
  logic [WIDTH-1:0] cnt_meta, s_cnt, cnt_prev;
  logic             m_meta, s_m, m_prev;
  logic [2:0]       pipe_vld;
  logic [3:0]       stab, stab_next;
  logic             grace, grace_next, grace_eff;
  logic             same, accept, up_step, dn_step, legal;
  logic [WIDTH-1:0] count_next;
  logic             valid_next, wrap_next, err_next;
  logic [7:0]       err_cnt_next;

  // pipe_vld marks when the synchronizer and history flops hold real samples,
  // so reset contents are never counted toward stability.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_meta <= '0;
      s_cnt    <= '0;
      cnt_prev <= '0;
      m_meta   <= 1'b0;
      s_m      <= 1'b0;
      m_prev   <= 1'b0;
      pipe_vld <= '0;
      stab     <= '0;
    end else begin
      cnt_meta <= cnt_in;
      s_cnt    <= cnt_meta;
      cnt_prev <= s_cnt;
      m_meta   <= m;
      s_m      <= m_meta;
      m_prev   <= s_m;
      pipe_vld <= {pipe_vld[1:0], 1'b1};
      stab     <= stab_next;
    end
  end

  always_comb begin
    same      = pipe_vld[2] && (s_cnt == cnt_prev);
    stab_next = '0;
    if (same) stab_next = (stab >= SETTLE_L) ? SETTLE_L : stab + 4'd1;
    accept    = (stab_next == SETTLE_L) && ((state == INIT) || (s_cnt != count_out));
    up_step   = (s_cnt == count_out + ONE);
    dn_step   = (s_cnt == count_out - ONE);
    grace_eff = grace || (s_m != m_prev);
    legal     = grace_eff ? (up_step || dn_step) : (s_m ? dn_step : up_step);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= INIT;
      count_out   <= '0;
      count_valid <= 1'b0;
      wrap        <= 1'b0;
      step_err    <= 1'b0;
      err_count   <= '0;
      grace       <= 1'b0;
    end else begin
      state       <= state_next;
      count_out   <= count_next;
      count_valid <= valid_next;
      wrap        <= wrap_next;
      step_err    <= err_next;
      err_count   <= err_cnt_next;
      grace       <= grace_next;
    end
  end

  // Grace lasts from a mode toggle until the next acceptance of any kind.
  always_comb begin
    state_next   = state;
    count_next   = count_out;
    valid_next   = count_valid;
    wrap_next    = 1'b0;
    err_next     = 1'b0;
    err_cnt_next = err_count;
    grace_next   = grace_eff;
    if (accept) begin
      grace_next = 1'b0;
      count_next = s_cnt;
      if (state == INIT) begin
        valid_next = 1'b1;
        state_next = TRACK;
      end else if (legal) begin
        wrap_next = (up_step && (count_out == ALL_ONES)) ||
                    (dn_step && (count_out == '0));
      end else begin
        err_next = 1'b1;
        if (err_count != 8'hFF) err_cnt_next = err_count + 8'd1;
      end
    end
  end

endmodule

// File: doc/ripple_count_checker.md
# ripple_count_checker

Synchronous monitor that sits directly downstream of the 4-bit ripple up/down counter. It samples the counter's asynchronous, glitch-prone outputs into the `clk` domain, filters ripple transients, and publishes a clean count. Each accepted value is checked against the counter mode `m`, producing wrap and step-error events and a saturating error tally for the system bench and status logic.

## Interface
- `WIDTH`, default 4: counter width; matches the ripple counter stage count.
- `SETTLE`, default 2: consecutive identical synchronized samples needed before a value is accepted; legal range 1..15.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `cnt_in` input WIDTH: raw ripple counter outputs, `{y3,y2,y1,y0}`; asynchronous to `clk`.
- `m` input 1: counter mode, 0 = up, 1 = down; asynchronous to `clk`.
- `count_out` output WIDTH: last accepted (settled) count.
- `count_valid` output 1: high once the first value has been accepted after reset.
- `wrap` output 1: one-cycle pulse on an accepted legal wrap step.
- `step_err` output 1: one-cycle pulse on an accepted illegal step.
- `err_count` output 8: number of step errors, saturating at 255.

## Operation
- Synchronizer:
  - 2-flop synchronizer on `cnt_in` (per bit) and on `m`.
  - Call the synchronized values `s_cnt` and `s_m`.
- Settle filter:
  - `s_cnt` is compared with its previous-cycle value.
  - If equal, the stability counter `stab` increments, saturating at SETTLE; if different, `stab` is cleared to 0.
  - A candidate is accepted when `stab` reaches SETTLE and `s_cnt` ≠ `count_out`, or when the block is in INIT.
- FSM:
  - INIT (reset state): no reference value exists. The first acceptance loads `count_out`, sets `count_valid`, and moves to TRACK. No step check is made and no pulse is produced.
  - TRACK: each acceptance loads `count_out` and classifies the step from prev = old `count_out` to new.
  - Up (`s_m`=0): new = prev+1 mod 2^WIDTH is legal. `wrap` pulses additionally when prev = 2^WIDTH−1 and new = 0.
  - Down (`s_m`=1): new = prev−1 mod 2^WIDTH is legal. `wrap` pulses additionally when prev = 0 and new = 2^WIDTH−1.
  - Mode grace: for the first acceptance after `s_m` toggles, a ±1 step in either direction is legal; wrap detection follows the actual step direction.
  - Any other step pulses `step_err` and increments `err_count`, saturating at 255. `count_out` still takes the new value so tracking resynchronizes.
- Arithmetic: all ±1 comparisons are modulo 2^WIDTH; `err_count` is unsigned and never wraps.
- Simultaneous events: `wrap` and `step_err` are mutually exclusive. At most one acceptance occurs per cycle.

## Timing
- Reset (`rst`=1 at a rising edge):
  - Synchronizer flops, `stab`, and `count_out` go to 0.
  - `count_valid`, `wrap`, `step_err` go to 0; `err_count` goes to 0; FSM goes to INIT.
  - Reset asserted mid-operation discards any pending candidate and grace state. The next acceptance is treated as a first value.
- Latency: take the first rising edge that samples a stable new `cnt_in` as edge 1. `count_out` and any pulse update on edge 3+SETTLE (edge 5 with SETTLE=2).
- Glitches: a `cnt_in` excursion shorter than SETTLE+1 clock periods after synchronization is never accepted.
- Pulse width: `wrap` and `step_err` are high exactly one cycle, coincident with the `count_out` update.
- `count_valid` rises in the same cycle as the first `count_out` load and stays high until reset.
- Holding `cnt_in` constant produces no further acceptances or pulses.

## Test plan
- Reset then hold `cnt_in`=4'h0: `count_valid` rises on edge 5 after reset release; `count_out`=0; no `wrap` or `step_err`.
- `m`=0, step `cnt_in` 0→1→…→F→0, each value held 8 cycles: 16 updates, exactly one `wrap` (F→0), `err_count`=0, each update 5 edges after the change.
- `m`=1, step 3→2→1→0→F: one `wrap` on 0→F, no `step_err`.
- `m`=0, glitch `cnt_in` 5→7 for 1 cycle then back to 5, then 6: the 7 is never accepted; 5→6 is legal; `err_count`=0.
- `m`=0, jump 2→9: `step_err` pulses once, `count_out`=9, `err_count`=1. Repeat 300 illegal jumps: `err_count` holds at 255.
- At `count_out`=6, toggle `m` 0→1, then `cnt_in`=7 (grace step, legal), then 6 (legal down), then 8: `step_err` only on 6→8. Assert `rst` mid-sequence: all outputs 0 on the next edge.
